// File: rtl/data_types_pkg.sv
// ============================================================================
// Module  : data_types (package)
// Brief   : Shared CDB term types and default requester count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package data_types;

    localparam int NUM_CDB_REQ = 4;
    localparam int TAG_W       = 6;

    typedef logic [TAG_W-1:0] rs_tag_t;
    typedef logic [31:0]      word32_t;

    typedef struct packed {
        logic    valid;
        rs_tag_t tag;
        word32_t value;
    } cdb_t;

endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_rr_picker.sv
// ============================================================================
// Module  : rr_picker
// Brief   : Combinational round-robin pick: first set request at or after ptr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         win_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    localparam int IDX_W = $clog2(N);

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) s = s - N;
        return IDX_W'(s);
    endfunction

    always_comb begin
        win_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any_o && req_i[wrap_add(ptr_i, k)]) begin
                win_o[wrap_add(ptr_i, k)] = 1'b1;
                idx_o = wrap_add(ptr_i, k);
                any_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module  : cdb_arbiter
// Brief   : One-entry slot per functional unit, round-robin onto a registered CDB.
//           Optional mispredict flush port enabled by macro CDB_ARB_FLUSH_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_arbiter
    import data_types::*;
#(
    parameter int N_REQ = NUM_CDB_REQ
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_REQ-1:0]      req_valid_i,
    input  cdb_t [N_REQ-1:0]      req_data_i,
    output logic [N_REQ-1:0]      req_ready_o,
    output cdb_t                  cdb_o,
    output logic [N_REQ-1:0]      grant_o
`ifdef CDB_ARB_FLUSH_EN
    ,
    input  logic                  flush_i
`endif
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0] occ_q, occ_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    cdb_t             cdb_q, cdb_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    rs_tag_t          tag_q [N_REQ];
    word32_t          val_q [N_REQ];

    logic [N_REQ-1:0] w_win;
    logic [IDX_W-1:0] w_idx;
    logic             w_any;
    logic [N_REQ-1:0] w_accept;
    logic             w_flush;
    logic [N_REQ-1:0] unused_req_valid;

`ifdef CDB_ARB_FLUSH_EN
    assign w_flush = flush_i;
`else
    assign w_flush = 1'b0;
`endif

    rr_picker #(.N(N_REQ)) u_picker (
        .req_i (occ_q),
        .ptr_i (ptr_q),
        .win_o (w_win),
        .idx_o (w_idx),
        .any_o (w_any)
    );

    // A draining slot can be refilled on the same edge, so streaming has no bubble.
    assign req_ready_o = ~occ_q | w_win;
    assign w_accept    = req_valid_i & req_ready_o & {N_REQ{~w_flush}};

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_slot
            // The incoming .valid bit is meaningless; req_valid_i carries the handshake.
            assign unused_req_valid[i] = req_data_i[i].valid;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    tag_q[i] <= '0;
                    val_q[i] <= '0;
                end else if (w_accept[i]) begin
                    tag_q[i] <= req_data_i[i].tag;
                    val_q[i] <= req_data_i[i].value;
                end
            end
        end
    endgenerate

    always_comb begin
        occ_d       = occ_q;
        ptr_d       = ptr_q;
        cdb_d       = cdb_q;
        cdb_d.valid = 1'b0;
        grant_d     = '0;
        if (w_flush) begin
            occ_d = '0;
            ptr_d = '0;
        end else begin
            if (w_any) begin
                cdb_d   = '{valid: 1'b1, tag: tag_q[w_idx], value: val_q[w_idx]};
                grant_d = w_win;
                ptr_d   = (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
            end
            occ_d = (occ_q & ~w_win) | w_accept;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q   <= '0;
            ptr_q   <= '0;
            cdb_q   <= '0;
            grant_q <= '0;
        end else begin
            occ_q   <= occ_d;
            ptr_q   <= ptr_d;
            cdb_q   <= cdb_d;
            grant_q <= grant_d;
        end
    end

    assign cdb_o   = cdb_q;
    assign grant_o = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// Module  : tb_cdb_arbiter
// Brief   : Directed scoreboard bench for cdb_arbiter (flush steps with CDB_ARB_FLUSH_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;
    import data_types::*;

    localparam int N = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [N-1:0]  req_valid_i;
    cdb_t [N-1:0]  req_data_i;
    logic [N-1:0]  req_ready_o;
    cdb_t          cdb_o;
    logic [N-1:0]  grant_o;
`ifdef CDB_ARB_FLUSH_EN
    logic          flush_i;
`endif

    always #5 clk_i = ~clk_i;

    cdb_arbiter #(.N_REQ(N)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .cdb_o       (cdb_o),
        .grant_o     (grant_o)
`ifdef CDB_ARB_FLUSH_EN
        ,
        .flush_i     (flush_i)
`endif
    );

    typedef struct {
        logic [N-1:0] grant;
        rs_tag_t      tag;
        word32_t      value;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int port, input int tag, input int val);
        exp_t e;
        e.grant       = '0;
        e.grant[port] = 1'b1;
        e.tag         = rs_tag_t'(tag);
        e.value       = word32_t'(val);
        sb.push_back(e);
    endtask

    task automatic drive(input int port, input int tag, input int val);
        req_valid_i[port] = 1'b1;
        req_data_i[port]  = '{valid: 1'b1, tag: rs_tag_t'(tag), value: word32_t'(val)};
    endtask

    // Advance one edge, then check the broadcast against the scoreboard head.
    task automatic tick(input logic exp_valid);
        exp_t e;
        @(posedge clk_i);
        #1;
        chk("cdb_valid", 64'(cdb_o.valid), 64'(exp_valid));
        if (cdb_o.valid === 1'b1) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL sb_underflow observed=broadcast tag=%0h value=%0h expected=no broadcast",
                       cdb_o.tag, cdb_o.value);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("cdb_tag",   64'(cdb_o.tag),   64'(e.tag));
                chk("cdb_value", 64'(cdb_o.value), 64'(e.value));
                chk("grant",     64'(grant_o),     64'(e.grant));
            end
        end else begin
            chk("grant_idle", 64'(grant_o), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n0, n3;
        logic a0, a3;

        rst_i       = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
`ifdef CDB_ARB_FLUSH_EN
        flush_i     = 1'b0;
`endif
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_cdb",   64'(cdb_o),   64'd0);
        chk("reset_grant", 64'(grant_o), 64'd0);
        rst_i = 1'b0;
        #1;
        chk("ready_after_reset", 64'(req_ready_o), 64'hF);

        // Contention: all four ports at once, ptr starts at 0.
        for (int p = 0; p < N; p++) begin
            drive(p, p, 10 + p);
            push(p, p, 10 + p);
        end
        tick(1'b0);
        req_valid_i = '0;
        chk("cont_ready0", 64'(req_ready_o), 64'b0001);
        tick(1'b1);
        chk("cont_ready1", 64'(req_ready_o), 64'b0011);
        tick(1'b1);
        chk("cont_ready2", 64'(req_ready_o), 64'b0111);
        tick(1'b1);
        chk("cont_ready3", 64'(req_ready_o), 64'b1111);
        tick(1'b1);
        tick(1'b0);

        // Fairness: ports 0 and 3 permanently valid, four results each.
        n0 = 0;
        n3 = 0;
        for (int k = 0; k < 4; k++) begin
            push(0, 0, 200 + k);
            push(3, 3, 300 + k);
        end
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (n0 < 4) drive(0, 0, 200 + n0); else req_valid_i[0] = 1'b0;
            if (n3 < 4) drive(3, 3, 300 + n3); else req_valid_i[3] = 1'b0;
            a0 = req_valid_i[0] & req_ready_o[0];
            a3 = req_valid_i[3] & req_ready_o[3];
            tick(cyc >= 1 && cyc <= 8);
            if (a0) n0++;
            if (a3) n3++;
        end
        req_valid_i = '0;
        chk("fair_accepted0", 64'(n0), 64'd4);
        chk("fair_accepted3", 64'(n3), 64'd4);

        // Single port: one-cycle latency and one-cycle hold.
        drive(1, 1, 31);
        push(1, 1, 31);
        tick(1'b0);
        req_valid_i = '0;
        tick(1'b1);
        tick(1'b0);

        // Back-to-back stream on port 2.
        for (int k = 0; k < 5; k++) begin
            drive(2, 2, 100 + k);
            push(2, 2, 100 + k);
            tick(k != 0);
            chk("b2b_ready", 64'(req_ready_o[2]), 64'd1);
        end
        req_valid_i = '0;
        tick(1'b1);
        tick(1'b0);

        // Reset mid-traffic with slots 0 and 2 full; slot 2 must never appear.
        drive(0, 0, 50);
        drive(2, 2, 52);
        tick(1'b0);
        req_valid_i = '0;
        push(0, 0, 50);
        tick(1'b1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_reset_cdb",   64'(cdb_o),   64'd0);
        chk("async_reset_grant", 64'(grant_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        chk("ready_after_midreset", 64'(req_ready_o), 64'hF);
        repeat (3) tick(1'b0);

`ifdef CDB_ARB_FLUSH_EN
        // Flush with three slots full and ptr away from 0.
        drive(0, 0, 60);
        drive(1, 1, 61);
        drive(2, 2, 62);
        tick(1'b0);
        req_valid_i = '0;
        push(0, 0, 60);
        drive(3, 3, 63);
        tick(1'b1);
        req_valid_i = '0;
        flush_i     = 1'b1;
        drive(0, 0, 99);
        chk("flush_req_ready", 64'(req_ready_o[0]), 64'd1);
        tick(1'b0);
        flush_i     = 1'b0;
        req_valid_i = '0;
        chk("ready_after_flush", 64'(req_ready_o), 64'hF);
        repeat (2) tick(1'b0);
        drive(0, 0, 80);
        drive(1, 1, 81);
        push(0, 0, 80);
        push(1, 1, 81);
        tick(1'b0);
        req_valid_i = '0;
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
`endif

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
